// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter for one 16-bit score per request: two bytes back to back,
// byte order selectable, with a combinational ready handshake for the upstream sender.
module uart_word_tx #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter bit          HI_BYTE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_tx_value,
    input  logic        i_start_tx,
    output logic        o_uart_ready,
    output logic        o_tx_busy,
    output logic        o_word_done,
    output logic        o_txd
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic              r_byte_sel;
    logic              w_byte_sel_nxt;
    logic [15:0]       r_shift;
    logic [15:0]       w_shift_nxt;
    logic              r_txd;
    logic              r_tx_busy;
    logic              r_word_done;
    logic              w_txd_nxt;
    logic              w_word_done_nxt;
    logic              w_baud_wrap;

    assign w_baud_wrap = (r_baud == BAUD_LAST);

    // State register and registered outputs; all registers return to idle on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_byte_sel  <= 1'b0;
            r_shift     <= '0;
            r_txd       <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_bit       <= w_bit_nxt;
            r_byte_sel  <= w_byte_sel_nxt;
            r_shift     <= w_shift_nxt;
            r_txd       <= w_txd_nxt;
            r_tx_busy   <= (w_state_nxt != S_IDLE);
            r_word_done <= w_word_done_nxt;
        end
    end

    // Next-state logic. The first byte on the wire always sits in r_shift[7:0], so the
    // data phase only ever shifts right; after eight shifts the second byte is in place.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = w_baud_wrap ? '0 : r_baud + BAUD_W'(1);
        w_bit_nxt      = r_bit;
        w_byte_sel_nxt = r_byte_sel;
        w_shift_nxt    = r_shift;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (i_start_tx) begin
                    w_shift_nxt    = HI_BYTE_FIRST ? {i_tx_value[7:0], i_tx_value[15:8]}
                                                   : i_tx_value;
                    w_bit_nxt      = '0;
                    w_byte_sel_nxt = 1'b0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    w_shift_nxt = {1'b0, r_shift[15:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_wrap) begin
                    if (!r_byte_sel) begin
                        w_byte_sel_nxt = 1'b1;
                        w_state_nxt    = S_START;
                    end else begin
                        w_byte_sel_nxt = 1'b0;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so txd lines up with the state it encodes.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // One cycle of lookahead so the registered pulse lands on the last stop-bit cycle.
    assign w_word_done_nxt = (r_state == S_STOP) && r_byte_sel && (r_baud == BAUD_PRE);

    assign o_uart_ready = (r_state == S_IDLE) & ~i_start_tx;
    assign o_tx_busy    = r_tx_busy;
    assign o_word_done  = r_word_done;
    assign o_txd        = r_txd;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: cycle-exact line model for fast-baud instances,
// a bench UART receiver for byte recovery, and a 434-clock instance for full-rate timing.
module tb_uart_word_tx;

    localparam int unsigned CF = 434;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] val_a, val_b, val_c;
    logic        start_a, start_b, start_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        txd_a, txd_b, txd_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q_a[$];
    logic [7:0] rx_q_c[$];

    typedef struct {
        logic [15:0] v;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    always #5 clk = ~clk;

    uart_word_tx #(.CLKS_PER_BIT(4), .HI_BYTE_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .i_tx_value(val_a), .i_start_tx(start_a),
        .o_uart_ready(rdy_a), .o_tx_busy(busy_a), .o_word_done(done_a), .o_txd(txd_a));

    uart_word_tx #(.CLKS_PER_BIT(4), .HI_BYTE_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .i_tx_value(val_b), .i_start_tx(start_b),
        .o_uart_ready(rdy_b), .o_tx_busy(busy_b), .o_word_done(done_b), .o_txd(txd_b));

    uart_word_tx #(.CLKS_PER_BIT(CF), .HI_BYTE_FIRST(1'b1)) u_c (
        .clk(clk), .reset(reset), .i_tx_value(val_c), .i_start_tx(start_c),
        .o_uart_ready(rdy_c), .o_tx_busy(busy_c), .o_word_done(done_c), .o_txd(txd_c));

    task automatic check_bit(input string name, input int k, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %b, expected %b", name, k, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after the start_tx cycle: 20 bit slots of c cycles each,
    // two frames of {start 0, 8 data bits LSB first, stop 1}, idle high outside.
    function automatic logic model_line(input logic [15:0] v, input bit hi, input int k, input int c);
        int         idx;
        int         pos;
        logic [7:0] b;
        if (k < 1 || k > 20 * c) return 1'b1;
        idx = (k - 1) / c;
        pos = idx % 10;
        b   = (((idx / 10) == 0) == hi) ? v[15:8] : v[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // {txd, busy, done, ready} of the selected instance
    function automatic logic [3:0] outs(input int which);
        case (which)
            0:       return {txd_a, busy_a, done_a, rdy_a};
            1:       return {txd_b, busy_b, done_b, rdy_b};
            default: return {txd_c, busy_c, done_c, rdy_c};
        endcase
    endfunction

    task automatic drive(input int which, input logic s, input logic [15:0] v);
        case (which)
            0:       begin start_a = s; val_a = v; end
            1:       begin start_b = s; val_b = v; end
            default: begin start_c = s; val_c = v; end
        endcase
    endtask

    // Called at a negedge with the instance idle; returns at the negedge of cycle 81,
    // when the instance is idle again, so a following call is back to back.
    task automatic run_trace(input int which, input logic [15:0] value, input bit hi,
                             input bit inject, input string name);
        logic [3:0] o;
        drive(which, 1'b1, value);
        #1;
        o = outs(which);
        check_bit({name, " ready_at_start"}, 0, o[0], 1'b0);
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk);
            if (k == 1 || (inject && k == 11)) drive(which, 1'b0, 16'h0000);
            o = outs(which);
            check_bit({name, " txd"},   k, o[3], model_line(value, hi, k, 4));
            check_bit({name, " busy"},  k, o[2], logic'(k <= 80));
            check_bit({name, " done"},  k, o[1], logic'(k == 80));
            check_bit({name, " ready"}, k, o[0], logic'(k == 81));
            if (inject && k == 10) drive(which, 1'b1, 16'hFFFF);
        end
    endtask

    // Bench UART receiver: detect start bit, sample at mid-bit, keep bytes with a valid stop.
    task automatic rx_loop(input int which, input int c);
        logic [7:0] b;
        logic [3:0] o;
        forever begin
            @(negedge clk);
            o = outs(which);
            if (o[3] === 1'b0) begin
                repeat (c / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c) @(negedge clk);
                    o = outs(which);
                    b[i] = o[3];
                end
                repeat (c) @(negedge clk);
                o = outs(which);
                if (o[3] === 1'b1) begin
                    if (which == 0) rx_q_a.push_back(b);
                    else            rx_q_c.push_back(b);
                end
            end
        end
    endtask

    task automatic check_bytes(input int which, input logic [7:0] b1, input logic [7:0] b2,
                               input string name);
        int         sz;
        logic [7:0] g1, g2;
        sz = (which == 0) ? rx_q_a.size() : rx_q_c.size();
        check_int({name, " rx_count"}, 32'(sz), 32'd2);
        if (sz >= 2) begin
            if (which == 0) begin g1 = rx_q_a.pop_front(); g2 = rx_q_a.pop_front(); end
            else            begin g1 = rx_q_c.pop_front(); g2 = rx_q_c.pop_front(); end
            check_int({name, " rx_byte1"}, 32'(g1), 32'(b1));
            check_int({name, " rx_byte2"}, 32'(g2), 32'(b2));
        end
        if (which == 0) rx_q_a.delete();
        else            rx_q_c.delete();
    endtask

    initial rx_loop(0, 4);
    initial rx_loop(2, int'(CF));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [3:0]  o;
        logic [15:0] v;
        int          gap;
        int          done_at;
        int          rdy_at;

        tbl[0] = '{16'h1234, 8'h12, 8'h34};
        tbl[1] = '{16'hABCD, 8'hAB, 8'hCD};
        tbl[2] = '{16'h0000, 8'h00, 8'h00};
        tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF};
        tbl[4] = '{16'h8000, 8'h80, 8'h00};
        tbl[5] = '{16'h7FFF, 8'h7F, 8'hFF};

        reset = 1'b1;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        drive(2, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        o = outs(0);
        check_bit("in_reset txd",  0, o[3], 1'b1);
        check_bit("in_reset busy", 0, o[2], 1'b0);
        check_bit("in_reset done", 0, o[1], 1'b0);

        reset = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            o = outs(w);
            check_int($sformatf("post_reset outs inst%0d", w), 32'(o), 32'h9);
        end

        // High byte first, 0x12 then 0x34
        run_trace(0, 16'h1234, 1'b1, 1'b0, "t2_1234");
        check_bytes(0, 8'h12, 8'h34, "t2_1234");

        // Low byte first with an ignored request mid-frame
        run_trace(1, 16'h8001, 1'b0, 1'b1, "t3_8001_lo");

        // Table of vectors, issued back to back as soon as ready rises
        for (int i = 0; i < 6; i++) begin
            run_trace(0, tbl[i].v, 1'b1, 1'b0, $sformatf("t4_tbl%0d", i));
            check_bytes(0, tbl[i].b1, tbl[i].b2, $sformatf("t4_tbl%0d", i));
        end

        // Random words with small idle gaps, both byte orders
        for (int i = 0; i < 6; i++) begin
            v   = 16'($urandom);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            run_trace(0, v, 1'b1, 1'b0, $sformatf("rand_hi%0d", i));
            check_bytes(0, v[15:8], v[7:0], $sformatf("rand_hi%0d", i));
            run_trace(1, v, 1'b0, 1'b0, $sformatf("rand_lo%0d", i));
        end

        // Asynchronous reset in cycle 30 of a frame while the line is low
        drive(0, 1'b1, 16'h0F0F);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        repeat (29) @(negedge clk);
        o = outs(0);
        check_bit("t5 txd_before_reset", 30, o[3], model_line(16'h0F0F, 1'b1, 30, 4));
        #2 reset = 1'b1;
        #1 o = outs(0);
        check_bit("t5 txd_async", 30, o[3], 1'b1);
        check_bit("t5 busy_async", 30, o[2], 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        o = outs(0);
        check_bit("t5 ready_after", 0, o[0], 1'b1);
        check_bit("t5 txd_after",   0, o[3], 1'b1);
        repeat (50) @(negedge clk);
        rx_q_a.delete();
        run_trace(0, 16'hC33C, 1'b1, 1'b0, "t5_next");
        check_bytes(0, 8'hC3, 8'h3C, "t5_next");

        // Full-rate instance: word timing and receiver recovery
        for (int i = 0; i < 5; i++) begin
            v = 16'($urandom);
            drive(2, 1'b1, v);
            #1 o = outs(2);
            check_bit($sformatf("t6_%0d ready_at_start", i), 0, o[0], 1'b0);
            done_at = -1;
            rdy_at  = -1;
            for (int k = 1; k <= 20 * int'(CF) + 10; k++) begin
                @(negedge clk);
                if (k == 1) drive(2, 1'b0, 16'h0000);
                o = outs(2);
                if (o[1] === 1'b1 && done_at < 0) done_at = k;
                if (o[0] === 1'b1) begin
                    rdy_at = k;
                    break;
                end
            end
            check_int($sformatf("t6_%0d done_cycle", i), 32'(done_at), 32'(20 * CF));
            check_int($sformatf("t6_%0d ready_cycle", i), 32'(rdy_at), 32'(20 * CF + 1));
            check_bytes(2, v[15:8], v[7:0], $sformatf("t6_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
